psum_acc_buffer: RTL and testbench

PSUM_ACC_BUFFER -- requirements
Module: psum_acc_buffer

---
 rtl/psum_acc_buffer.sv | 147 ++++++++++++++
 tb/tb_psum_acc_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_buffer.sv
// rtl/psum_acc_buffer.sv - partial-sum accumulation row buffer with saturating adds, ReLU read port and bulk clear
module psum_acc_buffer #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int SATURATE   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           acc_valid,
  output logic                           acc_ready,
  input  logic                           acc_clear,
  input  logic [ADDR_WIDTH-1:0]          acc_addr,
  input  logic [ARRAY_DIM-1:0]           acc_lane_en,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_in,
  input  logic                           rd_req_valid,
  output logic                           rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  input  logic                           rd_relu,
  output logic                           rd_data_valid,
  input  logic                           rd_data_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0] rd_data,
  input  logic                           clr_start,
  output logic                           clr_busy,
  output logic                           clr_done,
  output logic                           ovf_sticky
);
  localparam int ROW_W = ARRAY_DIM * ACC_WIDTH;
  localparam int W     = ACC_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;

  logic [ROW_W-1:0]      mem [DEPTH];
  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [ROW_W-1:0]      s2_data;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  acc_fire;
  logic                  rd_fire;
  logic [ROW_W-1:0]      acc_old;
  logic [ROW_W-1:0]      acc_new;
  logic                  acc_ovf;
  logic [W:0]            sum;
  logic [ROW_W-1:0]      rd_raw;
  logic [ROW_W-1:0]      rd_row;

  assign acc_ready    = (state == IDLE) && !clr_start;
  assign rd_req_ready = (state == IDLE) && (!rd_data_valid || rd_data_ready);
  assign acc_fire     = acc_valid && acc_ready;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  // Forward the in-flight stage-2 row so back-to-back beats to one row chain up.
  assign acc_old = (s2_valid && (s2_addr == acc_addr)) ? s2_data : mem[acc_addr];
  assign rd_raw  = mem[rd_addr];

  always_comb begin
    acc_new = acc_old;
    acc_ovf = 1'b0;
    sum     = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      sum = {acc_old[i*W+W-1], acc_old[i*W +: W]} + {psum_in[i*W+W-1], psum_in[i*W +: W]};
      if (acc_lane_en[i]) begin
        if (acc_clear) begin
          acc_new[i*W +: W] = psum_in[i*W +: W];
        end else if (sum[W] != sum[W-1]) begin
          acc_ovf = 1'b1;
          if (SATURATE != 0)
            acc_new[i*W +: W] = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          else
            acc_new[i*W +: W] = sum[W-1:0];
        end else begin
          acc_new[i*W +: W] = sum[W-1:0];
        end
      end
    end
  end

  always_comb begin
    rd_row = rd_raw;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      if (rd_relu && rd_raw[i*W+W-1]) rd_row[i*W +: W] = '0;
    end
  end

  // Storage is never reset; a reset edge also drops the write it coincides with.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (s2_valid)
        mem[s2_addr] <= s2_data;
      else if (state == CLEAR)
        mem[clr_addr] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      s2_valid      <= 1'b0;
      s2_addr       <= '0;
      s2_data       <= '0;
      clr_addr      <= '0;
      clr_busy      <= 1'b0;
      clr_done      <= 1'b0;
      ovf_sticky    <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      s2_valid <= acc_fire;
      if (acc_fire) begin
        s2_addr <= acc_addr;
        s2_data <= acc_new;
      end
      if (acc_fire && acc_ovf) ovf_sticky <= 1'b1;

      if (rd_fire) begin
        rd_data_valid <= 1'b1;
        rd_data       <= rd_row;
      end else if (rd_data_ready) begin
        rd_data_valid <= 1'b0;
      end

      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            clr_busy   <= 1'b1;
            ovf_sticky <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_acc_buffer.sv
// tb/tb_psum_acc_buffer.sv - scoreboard bench for psum_acc_buffer (saturating and wrapping instances)
module tb_psum_acc_buffer;
  localparam int DIM = 16;
  localparam int AW  = 32;
  localparam int DEP = 1024;
  localparam int ABW = 10;
  typedef logic [DIM*AW-1:0] row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_valid = 1'b0;
  logic acc_clear = 1'b0;
  logic [ABW-1:0] acc_addr = '0;
  logic [DIM-1:0] acc_lane_en = '0;
  row_t psum_in = '0;
  logic rd_req_valid = 1'b0;
  logic [ABW-1:0] rd_addr = '0;
  logic rd_relu = 1'b0;
  logic rd_data_ready = 1'b1;
  logic clr_start = 1'b0;

  logic acc_ready, rd_req_ready, rd_data_valid, clr_busy, clr_done, ovf_sticky;
  row_t rd_data;
  logic w_acc_ready, w_rd_req_ready, w_rd_data_valid, w_clr_busy, w_clr_done, w_ovf_sticky;
  row_t w_rd_data;

  int n_vec = 0;
  int n_err = 0;
  row_t q_sat[$];
  row_t q_wrap[$];

  always #5 clk = ~clk;

  psum_acc_buffer #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .DEPTH(DEP), .ADDR_WIDTH(ABW), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_clear(acc_clear),
    .acc_addr(acc_addr), .acc_lane_en(acc_lane_en), .psum_in(psum_in), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_relu(rd_relu), .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready), .rd_data(rd_data), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .ovf_sticky(ovf_sticky));

  psum_acc_buffer #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .DEPTH(DEP), .ADDR_WIDTH(ABW), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_ready(w_acc_ready), .acc_clear(acc_clear),
    .acc_addr(acc_addr), .acc_lane_en(acc_lane_en), .psum_in(psum_in), .rd_req_valid(rd_req_valid),
    .rd_req_ready(w_rd_req_ready), .rd_addr(rd_addr), .rd_relu(rd_relu), .rd_data_valid(w_rd_data_valid),
    .rd_data_ready(rd_data_ready), .rd_data(w_rd_data), .clr_start(clr_start), .clr_busy(w_clr_busy),
    .clr_done(w_clr_done), .ovf_sticky(w_ovf_sticky));

  function automatic row_t lane(int i, logic [31:0] v);
    row_t r = '0;
    r[i*AW +: AW] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_data_valid && rd_data_ready) begin
      if (q_sat.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_response: got 0x%0h expected none", rd_data);
      end else begin
        row_t es, ew;
        es = q_sat.pop_front();
        ew = q_wrap.pop_front();
        n_vec++;
        if (rd_data !== es) begin
          n_err++;
          $display("FAIL rd_data_sat: got 0x%0h expected 0x%0h", rd_data, es);
        end
        n_vec++;
        if (w_rd_data_valid !== 1'b1 || w_rd_data !== ew) begin
          n_err++;
          $display("FAIL rd_data_wrap: got 0x%0h expected 0x%0h", w_rd_data, ew);
        end
      end
    end
  end

  task automatic beat(input logic [ABW-1:0] a, input logic clr, input logic [DIM-1:0] en, input row_t p);
    acc_valid = 1'b1; acc_addr = a; acc_clear = clr; acc_lane_en = en; psum_in = p;
    chk("acc_ready_on_beat", {31'd0, acc_ready}, 32'd1);
    @(posedge clk); #1;
    acc_valid = 1'b0;
  endtask

  task automatic rd(input logic [ABW-1:0] a, input logic relu, input row_t e_sat, input row_t e_wrap);
    int w = 0;
    q_sat.push_back(e_sat);
    q_wrap.push_back(e_wrap);
    rd_req_valid = 1'b1; rd_addr = a; rd_relu = relu;
    while (!rd_req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!rd_req_ready) begin
      n_vec++; n_err++;
      $display("FAIL rd_req_timeout: got rd_req_ready=0 expected 1");
    end
    @(posedge clk); #1;
    rd_req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q_sat.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (q_sat.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_sat.size());
      q_sat.delete();
      q_wrap.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, done, bad;
    row_t held;

    // Reset state
    idle(3);
    chk("rst_rd_data_valid", {31'd0, rd_data_valid}, 0);
    chk("rst_rd_data_zero", {31'd0, |rd_data}, 0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 0);
    chk("rst_clr_done", {31'd0, clr_done}, 0);
    chk("rst_ovf", {31'd0, ovf_sticky}, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_acc_ready", {31'd0, acc_ready}, 1);
    chk("idle_rd_req_ready", {31'd0, rd_req_ready}, 1);

    // Preload rows, then bulk clear
    beat(10'd7, 1'b1, 16'hFFFF, lane(0, 32'h1234) | lane(15, 32'h55));
    beat(10'd1023, 1'b1, 16'hFFFF, lane(3, 32'hDEAD));
    idle(2);
    rd(10'd7, 1'b0, lane(0, 32'h1234) | lane(15, 32'h55), lane(0, 32'h1234) | lane(15, 32'h55));
    drain();

    clr_start = 1'b1;
    #1;
    chk("acc_ready_during_clr_start", {31'd0, acc_ready}, 0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    busy = 0; done = 0; bad = 0;
    for (int i = 0; i < 1100; i++) begin
      clr_start = (i == 500);
      #1;
      if (clr_busy) busy++;
      if (clr_busy && acc_ready) bad++;
      if (clr_done) done++;
      @(posedge clk); #1;
    end
    clr_start = 1'b0;
    chk("clr_busy_cycles", busy, DEP);
    chk("clr_done_pulses", done, 1);
    chk("acc_ready_in_clear", bad, 0);
    for (int a = 0; a < DEP; a++) rd(ABW'(a), 1'b0, '0, '0);
    drain();

    // Back-to-back beats to one row: 3 (clear), +4, +5
    beat(10'd5, 1'b1, 16'hFFFF, lane(0, 32'd3) | lane(1, 32'd1));
    beat(10'd5, 1'b0, 16'hFFFF, lane(0, 32'd4) | lane(1, 32'd1));
    beat(10'd5, 1'b0, 16'hFFFF, lane(0, 32'd5) | lane(1, 32'd1));
    idle(2);
    rd(10'd5, 1'b0, lane(0, 32'd12) | lane(1, 32'd3), lane(0, 32'd12) | lane(1, 32'd3));
    drain();

    // Positive and negative overflow
    beat(10'd9, 1'b1, 16'hFFFF, lane(0, 32'h7FFFFFF0) | lane(1, 32'h80000010));
    chk("ovf_before_sat", {31'd0, ovf_sticky}, 0);
    beat(10'd9, 1'b0, 16'hFFFF, lane(0, 32'h00000020) | lane(1, 32'hFFFFFFE0));
    chk("ovf_sticky_sat", {31'd0, ovf_sticky}, 1);
    chk("ovf_sticky_wrap", {31'd0, w_ovf_sticky}, 1);
    idle(2);
    rd(10'd9, 1'b0, lane(0, 32'h7FFFFFFF) | lane(1, 32'h80000000),
                    lane(0, 32'h80000010) | lane(1, 32'h7FFFFFF0));
    drain();

    // Lane enable: only lane 0 updates on a zero row
    beat(10'd11, 1'b0, 16'h0001, {DIM{32'd1}});
    idle(2);
    rd(10'd11, 1'b0, lane(0, 32'd1), lane(0, 32'd1));
    drain();

    // Read in the cycle of the write returns the old contents
    beat(10'd20, 1'b1, 16'hFFFF, lane(0, 32'h55));
    rd(10'd20, 1'b0, '0, '0);
    idle(2);
    rd(10'd20, 1'b0, lane(0, 32'h55), lane(0, 32'h55));
    drain();

    // ReLU and back-pressure
    beat(10'd13, 1'b1, 16'hFFFF, lane(0, 32'hFFFFFFF9) | lane(2, 32'd5));
    idle(2);
    rd(10'd13, 1'b1, lane(2, 32'd5), lane(2, 32'd5));
    rd(10'd13, 1'b0, lane(0, 32'hFFFFFFF9) | lane(2, 32'd5), lane(0, 32'hFFFFFFF9) | lane(2, 32'd5));
    drain();
    rd_data_ready = 1'b0;
    rd(10'd13, 1'b0, lane(0, 32'hFFFFFFF9) | lane(2, 32'd5), lane(0, 32'hFFFFFFF9) | lane(2, 32'd5));
    held = lane(0, 32'hFFFFFFF9) | lane(2, 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_held", {31'd0, rd_data_valid}, 1);
      chk("bp_lane0_stable", rd_data[31:0], held[31:0]);
      chk("bp_lane2_stable", rd_data[95:64], held[95:64]);
      chk("bp_rd_req_ready_low", {31'd0, rd_req_ready}, 0);
      @(posedge clk); #1;
    end
    rd_data_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drops_after_accept", {31'd0, rd_data_valid}, 0);
    drain();

    // Reset in the middle of a clear walk
    beat(10'd50, 1'b1, 16'hFFFF, lane(0, 32'h50));
    beat(10'd200, 1'b1, 16'hFFFF, lane(0, 32'hABC));
    idle(2);
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    chk("clr_start_clears_ovf", {31'd0, ovf_sticky}, 0);
    chk("clr_busy_after_start", {31'd0, clr_busy}, 1);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("clr_busy_after_reset", {31'd0, clr_busy}, 0);
    chk("clr_done_after_reset", {31'd0, clr_done}, 0);
    rst_n = 1'b1;
    idle(1);
    rd(10'd50, 1'b0, '0, '0);
    rd(10'd200, 1'b0, lane(0, 32'hABC), lane(0, 32'hABC));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
